// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: MIPS pipeline-stage register (ID/EX, EX/MEM, MEM/WB) with
// valid/ready handshaking, a 2-entry skid buffer, synchronous flush and bubble
// insertion. Control bits read as zero whenever the stage holds nothing valid.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall/bubble counters.
module pipe_stage_buf #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,       // asynchronous, active-low
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // EMPTY = (main,skid) invalid; FULL = main only; SKID = both entries valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0]   main_data_reg, main_data_next;
  logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0]   skid_data_reg, skid_data_next;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic issue;

  assign main_valid = (state_reg != ST_EMPTY);
  assign skid_valid = (state_reg == ST_SKID);

  // Ready depends only on registered state, so there is no in->out comb path.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl_reg : '0;
  assign out_data  = main_data_reg;

  assign accept = in_valid & in_ready;
  assign issue  = main_valid & out_ready;

  // State and entry registers; data is only cleared by reset, never by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
    end
  end

  // Next-state and entry updates; flush wins over any accept in the same cycle.
  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;

    if (flush) begin
      state_next     = ST_EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_FULL;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ST_FULL: begin
          if (accept && issue) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (accept) begin
            state_next     = ST_SKID;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end else if (issue) begin
            state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // Skid entry is younger than main, so it moves up only after main issues.
          if (issue) begin
            state_next     = ST_FULL;
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_reg;

  // Saturating performance counters, sampled from pre-edge state; flush does not clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (!main_valid && (bubble_cnt_reg != {CNT_W{1'b1}}))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: reset, streaming,
// backpressure/skid ordering, flush, bubble insertion and (with
// PIPE_PERF_CNT_EN) counter saturation.
module tb_pipe_stage_buf;

  localparam int CTRL_W = 5;
  localparam int DATA_W = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int checks_cnt;
  int errors_cnt;

  pipe_stage_buf #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    drive(1'b0, '0, '0);

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b1;

    // ---------------- streaming 1..8 ----------------
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CTRL_W'(i), DATA_W'(i));
      tick();
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("stream_data_%0d", i),  out_data,       32'(i));
      check($sformatf("stream_ready_%0d", i), 32'(in_ready),  32'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("stream_drain_valid", 32'(out_valid), 32'd0);

    // ---------------- backpressure A,B,C ----------------
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h11);
    tick();
    check("bp_a_ready", 32'(in_ready), 32'd1);
    check("bp_a_data",  out_data,      32'h11);
    drive(1'b1, 5'd2, 32'h22);
    tick();
    check("bp_b_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 5'd3, 32'h33);
    tick();
    check("bp_c_held_ready", 32'(in_ready), 32'd0);
    check("bp_c_held_data",  out_data,      32'h11);
    out_ready = 1'b1;
    tick();
    check("bp_out_b_data",  out_data,       32'h22);
    check("bp_out_b_ctrl",  32'(out_ctrl),  32'd2);
    check("bp_out_b_ready", 32'(in_ready),  32'd1);
    tick();
    check("bp_out_c_data",  out_data,       32'h33);
    check("bp_out_c_valid", 32'(out_valid), 32'd1);
    drive(1'b0, '0, '0);
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'd0);

    // ---------------- flush in SKID ----------------
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'h44);
    tick();
    drive(1'b1, 5'd4, 32'h55);
    tick();
    check("fl_pre_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 5'd6, 32'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_out_ctrl",  32'(out_ctrl),  32'd0);
    check("fl_in_ready",  32'(in_ready),  32'd1);
    check("fl_data_held", out_data,       32'h44);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_no_ghost_%0d", i), 32'(out_valid), 32'd0);
    end
    drive(1'b1, 5'd7, 32'h77);
    tick();
    drive(1'b0, '0, '0);
    check("fl_after_data",  out_data,      32'h77);
    check("fl_after_ctrl",  32'(out_ctrl), 32'd7);
    tick();

    // ---------------- bubble insertion ----------------
    drive(1'b1, 5'b11111, 32'hAA);
    tick();
    check("bub_loaded_ctrl", 32'(out_ctrl), 32'h1f);
    drive(1'b0, '0, '0);
    tick();
    check("bub_valid", 32'(out_valid), 32'd0);
    check("bub_ctrl",  32'(out_ctrl),  32'd0);
    check("bub_data",  out_data,       32'hAA);

    // ---------------- reset mid-stream from SKID ----------------
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h99);
    tick();
    drive(1'b1, 5'd10, 32'hBB);
    tick();
    drive(1'b0, '0, '0);
    check("mid_skid_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ctrl",  32'(out_ctrl),  32'd0);
    check("mid_rst_data",  out_data,       32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    tick();
    reset = 1'b1;

`ifdef PIPE_PERF_CNT_EN
    // ---------------- performance counters ----------------
    check("cnt_rst_stall",  32'(stall_cnt),  32'd0);
    check("cnt_rst_bubble", 32'(bubble_cnt), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("cnt_idle_bubble", 32'(bubble_cnt), 32'd3);
    check("cnt_idle_stall",  32'(stall_cnt),  32'd0);
    drive(1'b1, 5'd1, 32'h1);
    tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    check("cnt_stall_sat",   32'(stall_cnt),  32'd15);
    check("cnt_bubble_hold", 32'(bubble_cnt), 32'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("cnt_flush_stall", 32'(stall_cnt), 32'd15);
    reset = 1'b0;
    #1;
    check("cnt_rst2_stall",  32'(stall_cnt),  32'd0);
    check("cnt_rst2_bubble", 32'(bubble_cnt), 32'd0);
    tick();
    reset = 1'b1;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
